cell_painter: RTL and testbench

CELL_PAINTER -- requirements
Module: cell_painter

---
 rtl/tetris_pkg.sv | 17 +
 rtl/cell_painter.sv | 134 +++++++++++++
 tb/tb_cell_painter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// Shared definitions for the Tetris display path: painter FSM states,
// default cell/screen geometry and the RGB 3-3-3 colour width.
package tetris_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PAINT = 2'd1,
    DONE  = 2'd2
  } painter_state_t;

  localparam int CELL_W_DEFAULT = 64;
  localparam int CELL_H_DEFAULT = 24;
  localparam int SCR_W_DEFAULT  = 640;
  localparam int SCR_H_DEFAULT  = 480;
  localparam int COLOUR_W       = 9;

endpackage

// File: rtl/cell_painter.sv
// Paints one CELL_W x CELL_H rectangle into the frame buffer in raster order,
// skipping off-screen pixels and stalling on plot_ready back-pressure.
module cell_painter
  import tetris_pkg::*;
#(
  parameter int CELL_W = CELL_W_DEFAULT,
  parameter int CELL_H = CELL_H_DEFAULT,
  parameter int SCR_W  = SCR_W_DEFAULT,
  parameter int SCR_H  = SCR_H_DEFAULT
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic                start,
  input  logic [9:0]          x0,
  input  logic [8:0]          y0,
  input  logic [COLOUR_W-1:0] color,
  output logic                busy,
  output logic                done,
  output logic [9:0]          plot_x,
  output logic [8:0]          plot_y,
  output logic [COLOUR_W-1:0] plot_colour,
  output logic                plot_we,
  input  logic                plot_ready
);

  localparam int DX_W = (CELL_W > 1) ? $clog2(CELL_W) : 1;
  localparam int DY_W = (CELL_H > 1) ? $clog2(CELL_H) : 1;
  localparam logic [DX_W-1:0] DX_LAST = DX_W'(CELL_W - 1);
  localparam logic [DY_W-1:0] DY_LAST = DY_W'(CELL_H - 1);

  painter_state_t state, state_next;

  logic [DX_W-1:0]     dx;
  logic [DY_W-1:0]     dy;
  logic [9:0]          x0_l;
  logic [8:0]          y0_l;
  logic [COLOUR_W-1:0] color_l;
  logic [9:0]          last_x;
  logic [8:0]          last_y;
  logic [COLOUR_W-1:0] last_colour;

  logic [10:0] sum_x;
  logic [9:0]  sum_y;
  logic        in_bounds;
  logic        last_pixel;
  logic        load;
  logic        advance;

  // One extra bit so a cell hanging off the right/bottom edge is clipped
  // rather than wrapping around to the left/top of the screen.
  assign sum_x      = {1'b0, x0_l} + 11'(dx);
  assign sum_y      = {1'b0, y0_l} + 10'(dy);
  assign in_bounds  = (sum_x < 11'(SCR_W)) && (sum_y < 10'(SCR_H));
  assign last_pixel = (dx == DX_LAST) && (dy == DY_LAST);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      dx          <= '0;
      dy          <= '0;
      x0_l        <= '0;
      y0_l        <= '0;
      color_l     <= '0;
      last_x      <= '0;
      last_y      <= '0;
      last_colour <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        x0_l    <= x0;
        y0_l    <= y0;
        color_l <= color;
        dx      <= '0;
        dy      <= '0;
      end else if (advance) begin
        if (dx == DX_LAST) begin
          dx <= '0;
          dy <= (dy == DY_LAST) ? '0 : dy + DY_W'(1);
        end else begin
          dx <= dx + DX_W'(1);
        end
      end
      // Remember what was presented so the outputs hold once PAINT ends.
      if (state == PAINT) begin
        last_x      <= sum_x[9:0];
        last_y      <= sum_y[8:0];
        last_colour <= color_l;
      end
    end
  end

  always_comb begin
    state_next  = state;
    load        = 1'b0;
    advance     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    plot_we     = 1'b0;
    plot_x      = last_x;
    plot_y      = last_y;
    plot_colour = last_colour;

    unique case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = PAINT;
        end
      end
      PAINT: begin
        busy        = 1'b1;
        plot_x      = sum_x[9:0];
        plot_y      = sum_y[8:0];
        plot_colour = color_l;
        plot_we     = in_bounds;
        advance     = plot_ready || !in_bounds;
        if (advance && last_pixel) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load       = 1'b1;
          state_next = PAINT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cell_painter.sv
// Self-checking bench for cell_painter: a pixel-list reference model is
// replayed cycle by cycle against the DUT under several ready/start patterns.
module tb_cell_painter;

  localparam int CW = 64;
  localparam int CH = 24;
  localparam int SW = 640;
  localparam int SH = 480;

  typedef struct {
    int x;
    int y;
    bit vis;
  } pix_t;

  logic       CLOCK_50 = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [9:0] x0 = '0;
  logic [8:0] y0 = '0;
  logic [8:0] color = '0;
  logic       plot_ready = 1'b0;
  logic       busy;
  logic       done;
  logic [9:0] plot_x;
  logic [8:0] plot_y;
  logic [8:0] plot_colour;
  logic       plot_we;

  int compared = 0;
  int mismatched = 0;
  int writes;

  pix_t model_q[$];

  cell_painter dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .start      (start),
    .x0         (x0),
    .y0         (y0),
    .color      (color),
    .busy       (busy),
    .done       (done),
    .plot_x     (plot_x),
    .plot_y     (plot_y),
    .plot_colour(plot_colour),
    .plot_we    (plot_we),
    .plot_ready (plot_ready)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every pixel of the cell in raster order, flagged visible when on screen.
  task automatic build_model(input int cx, input int cy);
    model_q.delete();
    for (int r = 0; r < CH; r++) begin
      for (int c = 0; c < CW; c++) begin
        pix_t p;
        p.x   = (cx + c) % 1024;
        p.y   = (cy + r) % 512;
        p.vis = ((cx + c) < SW) && ((cy + r) < SH);
        model_q.push_back(p);
      end
    end
  endtask

  // Called at a negedge; returns at the negedge of the first PAINT cycle.
  task automatic issue_start(input int cx, input int cy, input int cc);
    x0    = 10'(cx);
    y0    = 9'(cy);
    color = 9'(cc);
    start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
  endtask

  task automatic run_body(input int cx, input int cy, input int cc, input int mode,
                          input int spur_at, input int abort_at, input bit chain,
                          input int nx, input int ny, input int nc,
                          output int n_writes);
    int k;
    int popped;
    int last_x;
    int last_y;
    bit rdy_toggle;
    k = 0;
    popped = 0;
    n_writes = 0;
    rdy_toggle = 1'b1;
    build_model(cx, cy);
    last_x = model_q[model_q.size() - 1].x;
    last_y = model_q[model_q.size() - 1].y;
    while (model_q.size() > 0 && k < 4 * CW * CH + 100) begin
      if (popped == abort_at) begin
        resetn = 1'b0;
        start  = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_we", plot_we, 0);
        check("abort_done", done, 0);
        check("abort_x", plot_x, 0);
        check("abort_colour", plot_colour, 0);
        @(negedge CLOCK_50);
        check("abort_no_done", done, 0);
        resetn = 1'b1;
        return;
      end
      case (mode)
        0: plot_ready = 1'b1;
        1: begin plot_ready = rdy_toggle; rdy_toggle = ~rdy_toggle; end
        default: plot_ready = 1'($urandom_range(0, 1));
      endcase
      x0    = 10'($urandom);
      y0    = 9'($urandom);
      color = 9'($urandom);
      if (k == spur_at) begin
        color = 9'(~cc);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      check("busy", busy, 1);
      check("done_low", done, 0);
      check("we", plot_we, model_q[0].vis);
      if (model_q[0].vis) begin
        check("plot_x", plot_x, model_q[0].x);
        check("plot_y", plot_y, model_q[0].y);
        check("plot_colour", plot_colour, cc);
        if (plot_ready) n_writes++;
      end
      if (!model_q[0].vis || plot_ready) begin
        void'(model_q.pop_front());
        popped++;
      end
      @(negedge CLOCK_50);
      k++;
    end
    check("no_timeout", model_q.size(), 0);
    start = 1'b0;
    if (mode == 0) check("latency", k, CW * CH);
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("done_we", plot_we, 0);
    check("hold_x", plot_x, last_x);
    check("hold_y", plot_y, last_y);
    check("hold_colour", plot_colour, cc);
    if (chain) begin
      issue_start(nx, ny, nc);
      check("chain_busy", busy, 1);
    end else begin
      @(negedge CLOCK_50);
      check("idle_done", done, 0);
      check("idle_busy", busy, 0);
      check("idle_we", plot_we, 0);
      check("idle_hold_x", plot_x, last_x);
    end
  endtask

  initial begin
    int cx;
    int cy;
    int cc;
    int nx;
    int ny;
    int nc;
    $display("[TB] cell_painter bench starting");
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we", plot_we, 0);
    check("rst_x", plot_x, 0);
    check("rst_y", plot_y, 0);
    check("rst_colour", plot_colour, 0);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    @(negedge CLOCK_50);

    issue_start(64, 48, 9'h1C7);
    run_body(64, 48, 9'h1C7, 0, -1, -1, 1'b0, 0, 0, 0, writes);
    check("writes_basic", writes, CW * CH);

    issue_start(64, 48, 9'h1C7);
    run_body(64, 48, 9'h1C7, 1, -1, -1, 1'b0, 0, 0, 0, writes);
    check("writes_toggle", writes, CW * CH);

    issue_start(576, 456, 9'h0A5);
    run_body(576, 456, 9'h0A5, 0, -1, -1, 1'b0, 0, 0, 0, writes);
    check("writes_corner", writes, CW * CH);

    issue_start(608, 456, 9'h13B);
    run_body(608, 456, 9'h13B, 0, -1, -1, 1'b0, 0, 0, 0, writes);
    check("writes_clipped", writes, 768);

    cc = 9'h055;
    issue_start(100, 200, cc);
    run_body(100, 200, cc, 0, 100, -1, 1'b0, 0, 0, 0, writes);
    check("writes_spur", writes, CW * CH);

    cx = int'($urandom_range(0, 570));
    cy = int'($urandom_range(0, 450));
    cc = int'($urandom_range(0, 511));
    nx = int'($urandom_range(0, 570));
    ny = int'($urandom_range(0, 450));
    nc = int'($urandom_range(0, 511));
    issue_start(cx, cy, cc);
    run_body(cx, cy, cc, 0, -1, -1, 1'b1, nx, ny, nc, writes);
    run_body(nx, ny, nc, 2, -1, -1, 1'b0, 0, 0, 0, writes);
    check("writes_chain", writes, CW * CH);

    issue_start(200, 100, 9'h1FF);
    run_body(200, 100, 9'h1FF, 0, -1, 700, 1'b0, 0, 0, 0, writes);
    @(negedge CLOCK_50);
    issue_start(300, 300, 9'h0F0);
    run_body(300, 300, 9'h0F0, 0, -1, -1, 1'b0, 0, 0, 0, writes);
    check("writes_after_abort", writes, CW * CH);

    for (int i = 0; i < 3; i++) begin
      cx = int'($urandom_range(0, 1023));
      cy = int'($urandom_range(0, 511));
      cc = int'($urandom_range(0, 511));
      issue_start(cx, cy, cc);
      run_body(cx, cy, cc, 2, -1, -1, 1'b0, 0, 0, 0, writes);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
